mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH_LOG2, default 6, word-address bits (64 x 32-bit words).
REQ-002 Parameter: WAIT_CYCLES, default 2, wait states before response (0..15).
REQ-003 Ports (the clock and reset are already decided; they are listed first):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  request strobe from the multicycle CPU datapath.
REQ-005 req_we  in  1  1 = store word, 0 = load word.
REQ-006 req_addr  in  32  byte address (PC or ALUOut, chosen by IorD upstream).
REQ-007 req_wdata  in  32  store data.
REQ-008 req_ready  out  1  responder can accept a request.
REQ-009 resp_valid  out  1  one-cycle response pulse.
REQ-010 resp_rdata  out  32  load data; 0 on stores and errors.
REQ-011 resp_err  out  1  qualifies resp_valid: access misaligned or out of range.

Function
REQ-012 FSM states: IDLE, WAIT, RESP.
REQ-013 IDLE: req_ready=1; req_valid=1 latches we/addr/wdata and enters WAIT; if WAIT_CYCLES=0 it enters RESP directly.
REQ-014 WAIT: 4-bit counter loaded with WAIT_CYCLES-1 on accept, decrements each cycle; counter==0 enters RESP.
REQ-015 RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in WAIT and RESP.
REQ-016 Latency: accept at edge N -> resp_valid high in cycle N+WAIT_CYCLES+1.
REQ-017 Inputs are ignored outside IDLE; latched values are used for the whole transaction.
REQ-018 Error if latched addr[1:0]!=0 or addr[31:DEPTH_LOG2+2]!=0: resp_err=1, rdata=0, no write.
REQ-019 A legal store commits at the clock edge that ends RESP, and only once.
REQ-020 A legal load drives mem[addr[DEPTH_LOG2+1:2]] on resp_rdata during RESP.
REQ-021 Back-to-back: req_valid held high is accepted in the first IDLE cycle after RESP; there is no IDLE bypass.
REQ-022 Load after store to the same word returns the new data.

Reset
REQ-023 reset asserted forces IDLE and counter 0, with req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
REQ-024 Reset during WAIT or RESP aborts the transaction: no write, no response.
REQ-025 Memory contents are not cleared by reset.

Configuration
REQ-026 Macro MEM_RESP_STATS_EN.
- Defined: 16-bit outputs stat_loads, stat_stores, stat_errs each count completed responses of that kind; they saturate at 0xFFFF and are cleared by reset.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Structure
REQ-027 Shared package mips_mem_pkg holds:
- state encodings IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
- WORD_W=32;
- the default WAIT_CYCLES.
REQ-028 Sub-module mem_array holds the storage: synchronous write, combinational read, parameter DEPTH_LOG2.

Verification
REQ-029 Reset, then load at addr 0x0 -> resp_valid in cycle 3 after accept, rdata equals the preloaded word, resp_err=0.
REQ-030 Store 0xDEADBEEF to 0x10, then load 0x10 -> rdata=0xDEADBEEF; req_ready=0 throughout WAIT and RESP.
REQ-031 Load at 0x6 (misaligned) and load at 0x100 (out of range, DEPTH_LOG2=6) -> resp_err=1, rdata=0; a store to 0x102 leaves memory unchanged.
REQ-032 Store 0x12345678 to 0x20, reset asserted in WAIT -> no resp_valid, state IDLE; load 0x20 returns the old value.
REQ-033 WAIT_CYCLES=0 with req_valid held high -> response every 2nd cycle, with alternating req_ready=1/0.
REQ-034 With MEM_RESP_STATS_EN defined: 3 loads, 2 stores, 1 error -> stat_loads=3, stat_stores=2, stat_errs=1.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the multicycle CPU memory responder: FSM encodings, word width, defaults.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package mips_mem_pkg;

    localparam int WORD_W          = 32;
    localparam int DEF_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Flags an access that is not word aligned or falls beyond the implemented word range.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int depth_log2);
        logic [WORD_W-1:0] hi;
        hi = addr >> (depth_log2 + 2);
        return (addr[1:0] != 2'b00) || (hi != '0);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for the responder: synchronous write, combinational read, no reset on contents.
// Latency: write lands at the clock edge, read is same-cycle.
// Backpressure: none; the caller sequences access.
module mem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WORD_W-1:0]     wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WORD_W-1:0]     rdata_o
);

    logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];

    // Contents survive reset on purpose, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder for a multicycle CPU; optional counters via MEM_RESP_STATS_EN.
// Latency: accept at edge N gives a one-cycle resp_valid in cycle N+WAIT_CYCLES+1.
// Backpressure: req_ready is low from accept until the response cycle ends; inputs ignored then.
module mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errs
`endif
);

    // Counter preload: the WAIT state lasts exactly WAIT_CYCLES cycles.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    we_q;
    logic                    err_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [WORD_W-1:0]       wdata_q;
    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic                    resp_err_q;
    logic [WORD_W-1:0]       resp_rdata_q;

    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic [WORD_W-1:0]       mem_rdata;
    logic                    mem_we;
    logic                    resp_err_d;
    logic [WORD_W-1:0]       resp_rdata_d;

    // Response values are computed on the edge that enters RESP. With zero wait
    // states that edge is the accept edge itself, so the live request is used
    // instead of the not-yet-latched copy.
    always_comb begin
        logic we_sel;
        rd_idx       = idx_q;
        resp_err_d   = err_q;
        we_sel       = we_q;
        if (state_q == IDLE) begin
            rd_idx     = req_addr[DEPTH_LOG2+1:2];
            resp_err_d = addr_err(req_addr, DEPTH_LOG2);
            we_sel     = req_we;
        end
        resp_rdata_d = (resp_err_d || we_sel) ? '0 : mem_rdata;
    end

    // A legal store commits on the single edge that ends RESP; an async reset
    // leaves state_q outside RESP, so an aborted store never writes.
    assign mem_we = (state_q == RESP) && we_q && !err_q;

    mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (rd_idx),
        .rdata_o (mem_rdata)
    );

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        err_q       <= addr_err(req_addr, DEPTH_LOG2);
                        idx_q       <= req_addr[DEPTH_LOG2+1:2];
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= resp_err_d;
                            resp_rdata_q <= resp_rdata_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= resp_err_d;
                        resp_rdata_q <= resp_rdata_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

`ifdef MEM_RESP_STATS_EN
    logic [15:0] stat_loads_q;
    logic [15:0] stat_stores_q;
    logic [15:0] stat_errs_q;

    // Count each completed response by kind, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_loads_q  <= 16'd0;
            stat_stores_q <= 16'd0;
            stat_errs_q   <= 16'd0;
        end else if (state_q == RESP) begin
            if (err_q) begin
                if (stat_errs_q != 16'hFFFF) stat_errs_q <= stat_errs_q + 16'd1;
            end else if (we_q) begin
                if (stat_stores_q != 16'hFFFF) stat_stores_q <= stat_stores_q + 16'd1;
            end else begin
                if (stat_loads_q != 16'hFFFF) stat_loads_q <= stat_loads_q + 16'd1;
            end
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at the default two wait states, one at zero.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid0;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;
`ifdef MEM_RESP_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errs;
    logic [15:0] stat_loads0, stat_stores0, stat_errs0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
`ifdef MEM_RESP_STATS_EN
        ,
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_errs   (stat_errs)
`endif
    );

    mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid0),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready0),
        .resp_valid (resp_valid0),
        .resp_rdata (resp_rdata0),
        .resp_err   (resp_err0)
`ifdef MEM_RESP_STATS_EN
        ,
        .stat_loads  (stat_loads0),
        .stat_stores (stat_stores0),
        .stat_errs   (stat_errs0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction on dut; returns the response, the latency in cycles after
    // the accept edge, and whether req_ready stayed low until the response.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat,
                       output logic rdy_low);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        // Junk on the bus while busy must not disturb the latched request.
        req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hBAD0_BAD0;
        lat = 1; rdy_low = 1'b1; rd = '0; er = 1'b0;
        while (!resp_valid && lat < 20) begin
            rdy_low = rdy_low & !req_ready;
            @(negedge clk);
            lat++;
        end
        rdy_low = rdy_low & !req_ready;
        rd = resp_rdata;
        er = resp_err;
        @(negedge clk);
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
    endtask

    logic [31:0] rd;
    logic        er, rl;
    int          lat;
    int          seen;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0;
        @(negedge clk);
        check("rst_ready",  32'(req_ready),  32'd1);
        check("rst_valid",  32'(resp_valid), 32'd0);
        check("rst_err",    32'(resp_err),   32'd0);
        check("rst_rdata",  resp_rdata,      32'd0);
        check("rst_state",  32'(dut.state_q), 32'd0);
        @(negedge clk); reset = 1'b0;

        // Preload word 0, then reset: contents must survive.
        txn(1'b1, 32'h0, 32'hA5A5_0001, rd, er, lat, rl);
        check("pre_st_lat", 32'(lat), 32'd3);
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;

        txn(1'b0, 32'h0, 32'h0, rd, er, lat, rl);
        check("ld0_lat",   32'(lat), 32'd3);
        check("ld0_rdata", rd,       32'hA5A5_0001);
        check("ld0_err",   32'(er),  32'd0);

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat, rl);
        check("st10_rdata", rd,      32'd0);
        check("st10_err",   32'(er), 32'd0);
        check("st10_busy",  32'(rl), 32'd1);
        txn(1'b0, 32'h10, 32'h0, rd, er, lat, rl);
        check("ld10_rdata", rd,      32'hDEAD_BEEF);
        check("ld10_busy",  32'(rl), 32'd1);

        txn(1'b0, 32'h6, 32'h0, rd, er, lat, rl);
        check("mis_err",   32'(er), 32'd1);
        check("mis_rdata", rd,      32'd0);
        txn(1'b0, 32'h100, 32'h0, rd, er, lat, rl);
        check("oor_err",   32'(er), 32'd1);
        check("oor_rdata", rd,      32'd0);
        // 0x102 would alias word 0 if the error did not block the write.
        txn(1'b1, 32'h102, 32'h1111_1111, rd, er, lat, rl);
        check("st102_err", 32'(er), 32'd1);
        txn(1'b0, 32'h0, 32'h0, rd, er, lat, rl);
        check("st102_nowr", rd, 32'hA5A5_0001);

        // Reset during WAIT aborts the store.
        txn(1'b1, 32'h20, 32'hCAFE_0020, rd, er, lat, rl);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_wait", 32'(dut.state_q), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_state", 32'(dut.state_q), 32'd0);
        check("abort_ready", 32'(req_ready),   32'd1);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("abort_noresp", 32'(seen), 32'd0);
        txn(1'b0, 32'h20, 32'h0, rd, er, lat, rl);
        check("abort_oldval", rd, 32'hCAFE_0020);

        // Zero wait states, request held: accept/respond alternate.
        @(negedge clk);
        req_valid0 = 1'b1; req_we = 1'b0; req_addr = 32'h8;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("w0_ready%0d", k), 32'(req_ready0),  (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("w0_valid%0d", k), 32'(resp_valid0), (k % 2 == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        req_valid0 = 1'b0;
        @(negedge clk);

`ifdef MEM_RESP_STATS_EN
        reset = 1'b1; @(negedge clk);
        check("stat_rst", 32'(stat_loads), 32'd0);
        reset = 1'b0;
        txn(1'b0, 32'h0,  32'h0, rd, er, lat, rl);
        txn(1'b0, 32'h10, 32'h0, rd, er, lat, rl);
        txn(1'b0, 32'h4,  32'h0, rd, er, lat, rl);
        txn(1'b1, 32'h8,  32'h0000_0008, rd, er, lat, rl);
        txn(1'b1, 32'hC,  32'h0000_000C, rd, er, lat, rl);
        txn(1'b0, 32'h6,  32'h0, rd, er, lat, rl);
        check("stat_loads",  32'(stat_loads),  32'd3);
        check("stat_stores", 32'(stat_stores), 32'd2);
        check("stat_errs",   32'(stat_errs),   32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
